pump_cmd_sequencer: RTL and testbench

Command-side partner of the pump timer. It turns debounced operator buttons and DHT11 humidity samples into the one-cycle timer_start, force_pulse and timer_stop pulses the pump timer consumes. It also drives the pump_select, period_seconds and pulse_on_time words, which are latched and held stable. It sits between the sensor/button front end and the pump timer, implements humidity hysteresis, and enforces spacing rules that keep the timer from dropping a command.

---
 rtl/pump_cmd_if.sv | 39 +++
 rtl/pump_cmd_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pump_cmd_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pump_cmd_if.sv
// Command bundle between the sensor/button front end, the sequencer and the pump timer.
// The slave side is the sequencer; the master side is whoever drives buttons and samples.
interface pump_cmd_if #(
    parameter int HUM_W = 8
);
    logic             btn_mode;
    logic             btn_force;
    logic             btn_stop;
    logic [HUM_W-1:0] humidity;
    logic             humidity_valid;
    logic [HUM_W-1:0] hum_low_th;
    logic [HUM_W-1:0] hum_high_th;
    logic [1:0]       sel_in;
    logic [31:0]      period_in;
    logic [31:0]      on_in;

    logic             timer_start;
    logic             force_pulse;
    logic             timer_stop;
    logic [1:0]       pump_select;
    logic [31:0]      period_seconds;
    logic [31:0]      pulse_on_time;
    logic             auto_active;
    logic             cfg_err;

    modport master (
        output btn_mode, btn_force, btn_stop, humidity, humidity_valid,
               hum_low_th, hum_high_th, sel_in, period_in, on_in,
        input  timer_start, force_pulse, timer_stop, pump_select,
               period_seconds, pulse_on_time, auto_active, cfg_err
    );

    modport slave (
        input  btn_mode, btn_force, btn_stop, humidity, humidity_valid,
               hum_low_th, hum_high_th, sel_in, period_in, on_in,
        output timer_start, force_pulse, timer_stop, pump_select,
               period_seconds, pulse_on_time, auto_active, cfg_err
    );
endinterface

// File: rtl/pump_cmd_sequencer.sv
// Turns button edges and humidity samples into single-cycle start/force/stop pulses
// for the pump timer, with hysteresis and a stop-to-start guard gap.
//
// state   | meaning
// S_OFF   | auto enabled, pump idle, waiting for low humidity
// S_RUN   | auto run in progress, waiting for high humidity
// S_HOLD  | auto disabled, only manual force / stop / mode honoured
// S_GUARD | post-stop spacing, all but btn_stop dropped
module pump_cmd_sequencer #(
    parameter int GAP_CYCLES = 4,
    parameter int HUM_W      = 8
) (
    input  logic      clk,
    input  logic      rst,
    pump_cmd_if.slave bus
);
    typedef enum logic [1:0] {S_OFF, S_RUN, S_HOLD, S_GUARD} state_t;

    localparam int               CNT_W    = $clog2(GAP_CYCLES) + 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_q, hold_d;
    logic             prev_stop_q, prev_mode_q, prev_force_q;
    logic             start_q, start_d;
    logic             force_q, force_d;
    logic             stop_q, stop_d;
    logic [1:0]       sel_q, sel_d;
    logic [31:0]      period_q, period_d;
    logic [31:0]      on_q, on_d;
    logic             err_q, err_d;

    logic             rise_stop, rise_mode, rise_force;
    logic             cfg_ok, hum_below, hum_above;
    logic [HUM_W-1:0] hum, lo_th, hi_th;

    assign hum   = bus.humidity;
    assign lo_th = bus.hum_low_th;
    assign hi_th = bus.hum_high_th;

    assign rise_stop  = bus.btn_stop  & ~prev_stop_q;
    assign rise_mode  = bus.btn_mode  & ~prev_mode_q;
    assign rise_force = bus.btn_force & ~prev_force_q;

    assign hum_below = bus.humidity_valid && (hum < lo_th);
    assign hum_above = bus.humidity_valid && (hum >= hi_th);
    assign cfg_ok    = (bus.sel_in != 2'd0) && (bus.period_in != 32'd0) &&
                       (bus.on_in != 32'd0) && (lo_th <= hi_th);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        start_d  = 1'b0;
        force_d  = 1'b0;
        stop_d   = 1'b0;
        sel_d    = sel_q;
        period_d = period_q;
        on_d     = on_q;
        err_d    = err_q;

        case (state_q)
            S_OFF: begin
                if (rise_stop || rise_mode) begin
                    stop_d  = 1'b1;
                    hold_d  = 1'b1;
                    cnt_d   = GAP_LOAD;
                    state_d = S_GUARD;
                end else if (rise_force) begin
                    force_d = 1'b1;
                end else if (hum_below) begin
                    if (cfg_ok) begin
                        start_d  = 1'b1;
                        sel_d    = bus.sel_in;
                        period_d = bus.period_in;
                        on_d     = bus.on_in;
                        err_d    = 1'b0;
                        state_d  = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (rise_stop || rise_mode) begin
                    stop_d  = 1'b1;
                    hold_d  = 1'b1;
                    cnt_d   = GAP_LOAD;
                    state_d = S_GUARD;
                end else if (hum_above) begin
                    stop_d  = 1'b1;
                    hold_d  = 1'b0;
                    cnt_d   = GAP_LOAD;
                    state_d = S_GUARD;
                end else if (rise_force) begin
                    force_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (rise_stop) begin
                    stop_d  = 1'b1;
                    hold_d  = 1'b1;
                    cnt_d   = GAP_LOAD;
                    state_d = S_GUARD;
                end else if (rise_mode) begin
                    state_d = S_OFF;
                end else if (rise_force) begin
                    force_d = 1'b1;
                end
            end
            S_GUARD: begin
                if (rise_stop) begin
                    stop_d = 1'b1;
                    hold_d = 1'b1;
                    cnt_d  = GAP_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = hold_q ? S_HOLD : S_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            hold_q   <= 1'b0;
            start_q  <= 1'b0;
            force_q  <= 1'b0;
            stop_q   <= 1'b0;
            sel_q    <= 2'd0;
            period_q <= 32'd0;
            on_q     <= 32'd0;
            err_q    <= 1'b0;
            // Track the live level so a button held through reset needs a release first.
            prev_stop_q  <= bus.btn_stop;
            prev_mode_q  <= bus.btn_mode;
            prev_force_q <= bus.btn_force;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            start_q      <= start_d;
            force_q      <= force_d;
            stop_q       <= stop_d;
            sel_q        <= sel_d;
            period_q     <= period_d;
            on_q         <= on_d;
            err_q        <= err_d;
            prev_stop_q  <= bus.btn_stop;
            prev_mode_q  <= bus.btn_mode;
            prev_force_q <= bus.btn_force;
        end
    end

    assign bus.timer_start    = start_q;
    assign bus.force_pulse    = force_q;
    assign bus.timer_stop     = stop_q;
    assign bus.pump_select    = sel_q;
    assign bus.period_seconds = period_q;
    assign bus.pulse_on_time  = on_q;
    assign bus.auto_active    = (state_q == S_RUN);
    assign bus.cfg_err        = err_q;
endmodule

// File: tb/tb_pump_cmd_sequencer.sv
// Directed walk-through of the pump command flows followed by random button/humidity
// traffic, all compared cycle by cycle against a mode-and-timestamp reference model.
module tb_pump_cmd_sequencer;
    localparam int GAP   = 4;
    localparam int HUM_W = 8;

    logic clk;
    logic rst;

    pump_cmd_if #(.HUM_W(HUM_W)) bus ();

    pump_cmd_sequencer #(.GAP_CYCLES(GAP), .HUM_W(HUM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: operating mode flags plus the edge time of the last stop pulse.
    bit          m_prev_stop, m_prev_mode, m_prev_force;
    bit          m_running, m_manual, m_guarding, m_manual_after;
    int          m_last_stop;
    bit          e_start, e_force, e_stop, e_err;
    logic [1:0]  e_sel;
    logic [31:0] e_per, e_on;

    bit obs_has_stop;
    int obs_last_stop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        bit r_stop, r_mode, r_force, cfg_ok, lo_hit, hi_hit;
        r_stop  = bus.btn_stop  && !m_prev_stop;
        r_mode  = bus.btn_mode  && !m_prev_mode;
        r_force = bus.btn_force && !m_prev_force;
        m_prev_stop  = bus.btn_stop;
        m_prev_mode  = bus.btn_mode;
        m_prev_force = bus.btn_force;
        lo_hit = bus.humidity_valid && (int'(bus.humidity) < int'(bus.hum_low_th));
        hi_hit = bus.humidity_valid && (int'(bus.humidity) >= int'(bus.hum_high_th));
        cfg_ok = (bus.sel_in != 0) && (bus.period_in != 0) && (bus.on_in != 0) &&
                 (int'(bus.hum_low_th) <= int'(bus.hum_high_th));
        cyc++;
        e_start = 0; e_force = 0; e_stop = 0;
        if (rst) begin
            m_running = 0; m_manual = 0; m_guarding = 0; m_manual_after = 0;
            e_err = 0; e_sel = 0; e_per = 0; e_on = 0;
            return;
        end
        if (m_guarding) begin
            if (r_stop) begin
                e_stop = 1; m_last_stop = cyc; m_manual_after = 1;
            end else if (cyc - m_last_stop >= GAP) begin
                m_guarding = 0; m_manual = m_manual_after;
            end
        end else if (m_running) begin
            if (r_stop || r_mode || hi_hit) begin
                e_stop = 1; m_last_stop = cyc; m_guarding = 1; m_running = 0;
                m_manual_after = r_stop || r_mode;
            end else if (r_force) begin
                e_force = 1;
            end
        end else if (m_manual) begin
            if (r_stop) begin
                e_stop = 1; m_last_stop = cyc; m_guarding = 1; m_manual = 0; m_manual_after = 1;
            end else if (r_mode) begin
                m_manual = 0;
            end else if (r_force) begin
                e_force = 1;
            end
        end else begin
            if (r_stop || r_mode) begin
                e_stop = 1; m_last_stop = cyc; m_guarding = 1; m_manual_after = 1;
            end else if (r_force) begin
                e_force = 1;
            end else if (lo_hit) begin
                if (cfg_ok) begin
                    e_start = 1; m_running = 1; e_err = 0;
                    e_sel = bus.sel_in; e_per = bus.period_in; e_on = bus.on_in;
                end else begin
                    e_err = 1;
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("timer_start", bus.timer_start, e_start);
        chk("force_pulse", bus.force_pulse, e_force);
        chk("timer_stop", bus.timer_stop, e_stop);
        chk("pump_select", bus.pump_select, e_sel);
        chk("period_seconds", bus.period_seconds, e_per);
        chk("pulse_on_time", bus.pulse_on_time, e_on);
        chk("cfg_err", bus.cfg_err, e_err);
        chk("auto_active", bus.auto_active, m_running);
        if (rst) obs_has_stop = 0;
        if (bus.timer_start && obs_has_stop)
            chk("stop_start_gap", (cyc - obs_last_stop >= GAP) ? 1 : 0, 1);
        if (bus.timer_stop) begin
            obs_has_stop  = 1;
            obs_last_stop = cyc;
        end
        bus.humidity_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic hum(input int v);
        bus.humidity       = HUM_W'(v);
        bus.humidity_valid = 1'b1;
        step();
    endtask

    task automatic cfg(input int sel, input int per, input int on, input int lo, input int hi);
        bus.sel_in      = 2'(sel);
        bus.period_in   = 32'(per);
        bus.on_in       = 32'(on);
        bus.hum_low_th  = HUM_W'(lo);
        bus.hum_high_th = HUM_W'(hi);
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_mode = 0; bus.btn_force = 0; bus.btn_stop = 0;
        bus.humidity = 0; bus.humidity_valid = 0;
        cfg(1, 10, 3, 40, 60);
        idle(2);
        rst = 1'b0;
        idle(1);

        // auto start, hysteresis, guard drop, restart after the gap
        hum(35);
        hum(50);
        hum(60);
        idle(1);
        hum(30);
        idle(GAP);
        hum(30);

        // rejected config then accepted
        hum(60);
        idle(GAP + 1);
        cfg(1, 0, 3, 40, 60);
        hum(30);
        cfg(1, 10, 3, 70, 60);
        hum(30);
        cfg(2, 20, 5, 40, 60);
        hum(30);

        // manual hold path
        bus.btn_stop = 1; step(); bus.btn_stop = 0;
        idle(GAP + 1);
        hum(10);
        bus.btn_force = 1; step(); bus.btn_force = 0; step();
        bus.btn_mode = 1; step(); bus.btn_mode = 0; step();
        hum(10);

        // leave to hold, back to off, then coincident stop/force/low-humidity
        bus.btn_mode = 1; step(); bus.btn_mode = 0;
        idle(GAP + 1);
        bus.btn_mode = 1; step(); bus.btn_mode = 0; step();
        bus.btn_stop = 1; bus.btn_force = 1;
        hum(10);
        idle(GAP + 2);
        bus.btn_stop = 0; bus.btn_force = 0;
        bus.btn_mode = 1; step(); bus.btn_mode = 0; step();

        // reset while running with a force press pending; force held through reset
        hum(10);
        bus.btn_force = 1; rst = 1'b1; step(); step();
        rst = 1'b0; idle(3);
        bus.btn_force = 0; step();
        bus.btn_force = 1; step(); bus.btn_force = 0; step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 11) == 0) bus.btn_stop  = ~bus.btn_stop;
            if ($urandom_range(0, 7)  == 0) bus.btn_mode  = ~bus.btn_mode;
            if ($urandom_range(0, 3)  == 0) bus.btn_force = ~bus.btn_force;
            bus.humidity_valid = ($urandom_range(0, 2) == 0);
            bus.humidity       = HUM_W'($urandom_range(0, 100));
            if ($urandom_range(0, 19) == 0) begin
                bus.sel_in    = 2'($urandom_range(0, 3));
                bus.period_in = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                bus.on_in     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                if ($urandom_range(0, 4) == 0) begin
                    bus.hum_low_th = 8'd70; bus.hum_high_th = 8'd60;
                end else begin
                    bus.hum_low_th  = HUM_W'($urandom_range(20, 50));
                    bus.hum_high_th = HUM_W'($urandom_range(50, 80));
                end
            end
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
